fifo_rd_stream: RTL and testbench

Read-side drain controller for the async FIFO. It sits in the `rclk` domain, pops words from the FIFO read port (`rd_en`/`empty`/`dout`, one-cycle read latency) and presents them on a valid/ready stream output. It sustains one word per cycle and never drops or duplicates a word under arbitrary back-pressure. It is the consumer end of the FIFO, replacing the bench-style toggled `rd_en` with a credit-based reader.

---
 rtl/fifo_rd_pkg.sv | 27 ++
 rtl/stream_skid_buf.sv | 52 +++++
 rtl/fifo_rd_stream.sv | 67 ++++++
 tb/tb_fifo_rd_stream.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared defaults and width helpers for the async-FIFO read-side stream drain.
package fifo_rd_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_BUF_DEPTH  = 3;
  localparam int unsigned DEF_CNT_WIDTH  = 16;

  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned OCC_W = occ_w(DEF_BUF_DEPTH);
  localparam int unsigned PTR_W = ptr_w(DEF_BUF_DEPTH);

  typedef logic [OCC_W-1:0] occ_t;
  typedef logic [PTR_W-1:0] ptr_t;

  typedef enum logic {
    RUN_IDLE   = 1'b0,
    RUN_ACTIVE = 1'b1
  } run_e;

endpackage

// File: rtl/stream_skid_buf.sv
// Small circular buffer: push at wr_ptr, pop at rd_ptr, head always visible.
module stream_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_BUF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic                         pop,
  output logic [DATA_WIDTH-1:0]        head,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned OW = occ_w(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop_ok = pop && (occ != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop_ok)      occ <= occ + OW'(1);
      else if (pop_ok && !push) occ <= occ - OW'(1);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (occ != OW'(DEPTH)));

endmodule

// File: rtl/fifo_rd_stream.sv
// Credit-based FIFO reader: pops the async FIFO read port into a valid/ready stream.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned BUF_DEPTH  = DEF_BUF_DEPTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                             rclk,
  input  logic                             rrst_n,
  input  logic                             drain_en,
  input  logic                             fifo_empty,
  input  logic [DATA_WIDTH-1:0]            fifo_dout,
  output logic                             fifo_rd_en,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   occupancy,
  output logic [CNT_WIDTH-1:0]             word_cnt
);

  localparam int unsigned OW = occ_w(BUF_DEPTH);
  localparam logic [OW:0] DEPTH_C = (OW+1)'(BUF_DEPTH);

  run_e          run_q;
  logic          inflight;
  logic [OW-1:0] occ;
  logic [OW:0]   credit_used;
  logic          pop;

  // A word in flight already owns a buffer slot; pops free slots only next cycle.
  assign credit_used = {1'b0, occ} + {{OW{1'b0}}, inflight};
  assign fifo_rd_en  = (run_q == RUN_ACTIVE) && drain_en && !fifo_empty
                       && (credit_used < DEPTH_C);
  assign m_valid     = (occ != '0);
  assign pop         = m_valid && m_ready;
  assign occupancy   = occ;

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_buf (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .push      (inflight),
    .push_data (fifo_dout),
    .pop       (pop),
    .head      (m_data),
    .occ       (occ)
  );

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      run_q    <= RUN_IDLE;
      inflight <= 1'b0;
      word_cnt <= '0;
    end else begin
      run_q    <= RUN_ACTIVE;
      inflight <= fifo_rd_en;
      if (pop) word_cnt <= word_cnt + CNT_WIDTH'(1);
    end
  end

  a_no_read_on_empty: assert property (@(posedge rclk) disable iff (!rrst_n)
    fifo_rd_en |-> !fifo_empty);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized and directed bench for fifo_rd_stream against a queue-based reference model.
module tb_fifo_rd_stream;

  localparam int DEPTH = 3;

  logic        rclk = 1'b0;
  logic        rrst_n = 1'b0;
  logic        drain_en = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_dout = '0;
  logic        fifo_rd_en;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [1:0]  occupancy;
  logic [15:0] word_cnt;

  fifo_rd_stream #(
    .DATA_WIDTH (8),
    .BUF_DEPTH  (DEPTH),
    .CNT_WIDTH  (16)
  ) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .drain_en   (drain_en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .occupancy  (occupancy),
    .word_cnt   (word_cnt)
  );

  always #5 rclk = ~rclk;

  int total = 0;
  int bad   = 0;

  // FIFO environment: the bench writes, the monitor reads
  logic [7:0]  fifo_mem [1024];
  int unsigned fifo_wr_cnt = 0;
  int unsigned fifo_rd_cnt = 0;
  logic        empty_force = 1'b0;
  assign fifo_empty = empty_force || (fifo_wr_cnt == fifo_rd_cnt);

  // reference model: buffered words as a queue, plus in-flight/run flags
  logic [7:0]  mdl_buf [$];
  bit          mdl_inflight = 0;
  bit          mdl_run = 0;
  int unsigned mdl_cnt = 0;
  logic [7:0]  land_word = '0;
  logic [7:0]  got_q [$];
  int unsigned n_reads = 0;
  bit          mdl_rd;

  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      mdl_buf.delete();
      mdl_inflight = 0;
      mdl_run      = 0;
      mdl_cnt      = 0;
      fifo_dout   <= '0;
    end else begin
      mdl_rd = mdl_run && drain_en && !fifo_empty && ((mdl_buf.size() + int'(mdl_inflight)) < DEPTH);
      if (m_valid && m_ready) got_q.push_back(m_data);
      if (fifo_rd_en) n_reads++;
      if (mdl_buf.size() != 0 && m_ready) begin
        void'(mdl_buf.pop_front());
        mdl_cnt = (mdl_cnt + 1) % 65536;
      end
      if (mdl_inflight) mdl_buf.push_back(land_word);
      mdl_inflight = mdl_rd;
      mdl_run      = 1;
      if (fifo_rd_en && fifo_rd_cnt != fifo_wr_cnt) begin
        land_word = fifo_mem[fifo_rd_cnt % 1024];
        fifo_rd_cnt++;
        fifo_dout <= land_word;
      end
    end
  end

  task automatic push_word(input logic [7:0] w);
    fifo_mem[fifo_wr_cnt % 1024] = w;
    fifo_wr_cnt++;
  endtask

  task automatic do_reset();
    @(negedge rclk);
    rrst_n = 1'b0; drain_en = 1'b0; m_ready = 1'b0; empty_force = 1'b0;
    fifo_wr_cnt = fifo_rd_cnt;
    @(negedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    total++; if (m_data !== 8'h00) begin bad++; $display("FAIL reset_m_data got=%h exp=00", m_data); end
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    total++; if (word_cnt !== 16'd0) begin bad++; $display("FAIL reset_word_cnt got=%0d exp=0", word_cnt); end
  endtask

  task automatic test_full_rate();
    int  first_rd = -1, first_v = -1, rd_run = 0, rd_max = 0;
    int  base;
    bit  exp_rd;
    base = got_q.size();
    for (int k = 1; k <= 30; k++) push_word(8'(k));
    drain_en = 1'b1; m_ready = 1'b1;
    @(negedge rclk); rrst_n = 1'b1; #1;
    total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL run_gate got=%b exp=0", fifo_rd_en); end
    for (int i = 0; i < 40; i++) begin
      @(negedge rclk); #1;
      exp_rd = mdl_run && drain_en && !fifo_empty && ((mdl_buf.size() + int'(mdl_inflight)) < DEPTH);
      total++; if (fifo_rd_en !== exp_rd) begin bad++; $display("FAIL full_rd_en cyc=%0d got=%b exp=%b", i, fifo_rd_en, exp_rd); end
      total++; if (occupancy !== 2'(mdl_buf.size())) begin bad++; $display("FAIL full_occ cyc=%0d got=%0d exp=%0d", i, occupancy, mdl_buf.size()); end
      total++; if (word_cnt !== 16'(mdl_cnt)) begin bad++; $display("FAIL full_cnt cyc=%0d got=%0d exp=%0d", i, word_cnt, mdl_cnt); end
      if (fifo_rd_en) begin
        if (first_rd < 0) first_rd = i;
        rd_run++;
        if (rd_run > rd_max) rd_max = rd_run;
      end else rd_run = 0;
      if (m_valid && first_v < 0) first_v = i;
      if (first_v >= 0 && i < first_v + 30) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== 8'(i - first_v + 1)) begin
          bad++; $display("FAIL full_seq cyc=%0d got=%b/%h exp=1/%h", i, m_valid, m_data, 8'(i - first_v + 1));
        end
      end
    end
    total++; if (rd_max != 30) begin bad++; $display("FAIL full_rd_run got=%0d exp=30", rd_max); end
    total++; if (first_v != first_rd + 2) begin bad++; $display("FAIL full_latency got=%0d exp=%0d", first_v, first_rd + 2); end
    total++; if (word_cnt !== 16'd30) begin bad++; $display("FAIL full_final_cnt got=%0d exp=30", word_cnt); end
    total++; if (got_q.size() - base != 30) begin bad++; $display("FAIL full_count got=%0d exp=30", got_q.size() - base); end
  endtask

  task automatic test_toggle_ready();
    int  base;
    bit  exp_rd;
    do_reset();
    base = got_q.size();
    for (int k = 1; k <= 30; k++) push_word(8'(k));
    drain_en = 1'b1;
    for (int i = 0; i < 90; i++) begin
      @(negedge rclk);
      m_ready = (i % 2 == 0);
      #1;
      exp_rd = mdl_run && drain_en && !fifo_empty && ((mdl_buf.size() + int'(mdl_inflight)) < DEPTH);
      total++; if (fifo_rd_en !== exp_rd) begin bad++; $display("FAIL tog_rd_en cyc=%0d got=%b exp=%b", i, fifo_rd_en, exp_rd); end
      total++; if (occupancy !== 2'(mdl_buf.size())) begin bad++; $display("FAIL tog_occ cyc=%0d got=%0d exp=%0d", i, occupancy, mdl_buf.size()); end
      total++; if (m_valid !== (mdl_buf.size() != 0)) begin bad++; $display("FAIL tog_valid cyc=%0d got=%b", i, m_valid); end
      if (mdl_buf.size() != 0) begin
        total++; if (m_data !== mdl_buf[0]) begin bad++; $display("FAIL tog_data cyc=%0d got=%h exp=%h", i, m_data, mdl_buf[0]); end
      end
    end
    total++; if (got_q.size() - base != 30) begin bad++; $display("FAIL tog_count got=%0d exp=30", got_q.size() - base); end
    for (int k = 0; k < 30 && base + k < got_q.size(); k++) begin
      total++; if (got_q[base + k] !== 8'(k + 1)) begin bad++; $display("FAIL tog_order idx=%0d got=%h exp=%h", k, got_q[base + k], 8'(k + 1)); end
    end
  endtask

  task automatic test_hold();
    int unsigned rbase;
    int          base;
    do_reset();
    base = got_q.size(); rbase = n_reads;
    for (int k = 0; k < 10; k++) push_word(8'h40 + 8'(k));
    drain_en = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge rclk); #1;
      if (i >= 5) begin
        total++; if (occupancy !== 2'd3) begin bad++; $display("FAIL hold_occ cyc=%0d got=%0d exp=3", i, occupancy); end
        total++; if (m_valid !== 1'b1 || m_data !== 8'h40) begin bad++; $display("FAIL hold_head cyc=%0d got=%b/%h exp=1/40", i, m_valid, m_data); end
      end
    end
    total++; if (n_reads - rbase != 3) begin bad++; $display("FAIL hold_reads got=%0d exp=3", n_reads - rbase); end
    m_ready = 1'b1;
    repeat (20) @(negedge rclk);
    #1;
    total++; if (got_q.size() - base != 10) begin bad++; $display("FAIL hold_count got=%0d exp=10", got_q.size() - base); end
    for (int k = 0; k < 10 && base + k < got_q.size(); k++) begin
      total++; if (got_q[base + k] !== 8'h40 + 8'(k)) begin bad++; $display("FAIL hold_order idx=%0d got=%h exp=%h", k, got_q[base + k], 8'h40 + 8'(k)); end
    end
    total++; if (word_cnt !== 16'd10) begin bad++; $display("FAIL hold_cnt got=%0d exp=10", word_cnt); end
  endtask

  task automatic test_drain_and_empty();
    int unsigned rbase;
    int          base;
    do_reset();
    base = got_q.size(); rbase = n_reads;
    for (int k = 0; k < 8; k++) push_word(8'h80 + 8'(k));
    drain_en = 1'b1; m_ready = 1'b1;
    @(negedge rclk); #1;
    total++; if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL drain_first_rd got=%b exp=1", fifo_rd_en); end
    @(negedge rclk);
    drain_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL drain_off_rd cyc=%0d got=%b exp=0", i, fifo_rd_en); end
      @(negedge rclk);
    end
    total++; if (n_reads - rbase != 1) begin bad++; $display("FAIL drain_reads got=%0d exp=1", n_reads - rbase); end
    total++; if (got_q.size() - base != 1) begin bad++; $display("FAIL drain_landed got=%0d exp=1", got_q.size() - base); end
    drain_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      empty_force = (i % 2 == 0);
      #1;
      if (fifo_empty) begin
        total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL empty_rd cyc=%0d got=%b exp=0", i, fifo_rd_en); end
      end
      @(negedge rclk);
    end
    empty_force = 1'b0;
    repeat (15) @(negedge rclk);
    #1;
    total++; if (got_q.size() - base != 8) begin bad++; $display("FAIL empty_count got=%0d exp=8", got_q.size() - base); end
    for (int k = 0; k < 8 && base + k < got_q.size(); k++) begin
      total++; if (got_q[base + k] !== 8'h80 + 8'(k)) begin bad++; $display("FAIL empty_order idx=%0d got=%h exp=%h", k, got_q[base + k], 8'h80 + 8'(k)); end
    end
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    do_reset();
    for (int k = 0; k < 8; k++) push_word(8'h10 + 8'(k));
    drain_en = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge rclk); #1;
      if (mdl_buf.size() == 2 && mdl_inflight) hit = 1;
    end
    total++; if (!hit) begin bad++; $display("FAIL rmid_setup got=timeout exp=occ2_inflight1"); end
    #2;
    rrst_n = 1'b0;
    #1;
    total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL rmid_rd_en got=%b exp=0", fifo_rd_en); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", m_valid); end
    total++; if (m_data !== 8'h00) begin bad++; $display("FAIL rmid_data got=%h exp=00", m_data); end
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL rmid_occ got=%0d exp=0", occupancy); end
    total++; if (word_cnt !== 16'd0) begin bad++; $display("FAIL rmid_cnt got=%0d exp=0", word_cnt); end
    fifo_wr_cnt = fifo_rd_cnt;
    @(negedge rclk);
    rrst_n = 1'b1;
    push_word(8'hA5);
    m_ready = 1'b1;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge rclk); #1;
      if (m_valid) hit = 1;
    end
    total++; if (!hit) begin bad++; $display("FAIL rmid_new_word got=timeout exp=valid"); end
    total++; if (m_data !== 8'hA5) begin bad++; $display("FAIL rmid_new_data got=%h exp=a5", m_data); end
    @(negedge rclk); #1;
    total++; if (word_cnt !== 16'd1) begin bad++; $display("FAIL rmid_new_cnt got=%0d exp=1", word_cnt); end
  endtask

  task automatic test_random();
    int          base;
    int unsigned wbase;
    bit          exp_rd;
    bit          done = 0;
    do_reset();
    base = got_q.size(); wbase = fifo_wr_cnt;
    for (int i = 0; i < 300; i++) begin
      @(negedge rclk);
      drain_en    = ($urandom_range(0, 9) != 0);
      m_ready     = 1'($urandom_range(0, 1));
      empty_force = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 1) == 1 && fifo_wr_cnt - fifo_rd_cnt < 100) push_word(8'($urandom));
      #1;
      exp_rd = mdl_run && drain_en && !fifo_empty && ((mdl_buf.size() + int'(mdl_inflight)) < DEPTH);
      total++; if (fifo_rd_en !== exp_rd) begin bad++; $display("FAIL rnd_rd_en cyc=%0d got=%b exp=%b", i, fifo_rd_en, exp_rd); end
      total++; if (occupancy !== 2'(mdl_buf.size())) begin bad++; $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", i, occupancy, mdl_buf.size()); end
      total++; if (word_cnt !== 16'(mdl_cnt)) begin bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, word_cnt, mdl_cnt); end
      if (mdl_buf.size() != 0) begin
        total++; if (m_data !== mdl_buf[0]) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", i, m_data, mdl_buf[0]); end
      end
    end
    @(negedge rclk);
    drain_en = 1'b1; m_ready = 1'b1; empty_force = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge rclk); #1;
      if (fifo_wr_cnt == fifo_rd_cnt && mdl_buf.size() == 0 && !mdl_inflight) done = 1;
    end
    total++; if (!done) begin bad++; $display("FAIL rnd_drain got=timeout exp=empty"); end
    total++; if (got_q.size() - base != int'(fifo_wr_cnt - wbase)) begin
      bad++; $display("FAIL rnd_count got=%0d exp=%0d", got_q.size() - base, fifo_wr_cnt - wbase);
    end
    for (int k = 0; k < int'(fifo_wr_cnt - wbase) && base + k < got_q.size(); k++) begin
      if (got_q[base + k] !== fifo_mem[(wbase + k) % 1024]) begin
        total++; bad++;
        $display("FAIL rnd_order idx=%0d got=%h exp=%h", k, got_q[base + k], fifo_mem[(wbase + k) % 1024]);
      end else total++;
    end
  endtask

  task automatic test_wrap();
    bit hit = 0;
    do_reset();
    for (int k = 0; k < 8; k++) push_word(8'(k));
    drain_en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 70000 && !hit; i++) begin
      @(negedge rclk);
      push_word(8'(i));
      #1;
      if (mdl_cnt == 65535) hit = 1;
    end
    total++; if (!hit) begin bad++; $display("FAIL wrap_reach got=timeout exp=65535"); end
    total++; if (word_cnt !== 16'hFFFF || m_valid !== 1'b1) begin
      bad++; $display("FAIL wrap_pre got=%0d/%b exp=65535/1", word_cnt, m_valid);
    end
    @(negedge rclk); #1;
    total++; if (word_cnt !== 16'd0) begin bad++; $display("FAIL wrap_zero got=%0d exp=0", word_cnt); end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_toggle_ready();
    test_hold();
    test_drain_and_empty();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
